// File: rtl/audio_sfx_pkg.sv
// Requester ids, FSM state encoding and note-ROM track map shared by the SFX scheduler.
// Pure constants: no latency and no flow control.
package audio_sfx_pkg;

    localparam int NUM_SFX = 4;

    localparam int REQ_LOBBY    = 0;
    localparam int REQ_HIT      = 1;
    localparam int REQ_MISS     = 2;
    localparam int REQ_GAMEOVER = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_PLAY = 2'd3
    } sfx_state_e;

    // Each track occupies TRACK_LEN consecutive ROM words starting at TRACK_BASE (length >= 1).
    localparam int TRACK_BASE [NUM_SFX] = '{REQ_LOBBY: 0, REQ_HIT: 16, REQ_MISS: 32, REQ_GAMEOVER: 48};
    localparam int TRACK_LEN  [NUM_SFX] = '{REQ_LOBBY: 3, REQ_HIT: 2,  REQ_MISS: 2,  REQ_GAMEOVER: 4};

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave tone from a half-period delay; combinational tone from registered phase, delay 0 = rest.
// No backpressure: the phase keeps running while play_i is high regardless of the sample sink.
module sfx_tone_gen #(
    parameter int DELAY_W   = 19,
    parameter int AMPLITUDE = 100000000
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_i,
    input  logic [DELAY_W-1:0]  delay_i,
    input  logic                play_i,
    output logic signed [31:0]  tone_o
);

    localparam logic signed [31:0] AMP = 32'(AMPLITUDE);

    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [DELAY_W-1:0] half_cnt_q, half_cnt_d;
    logic               phase_q, phase_d;
    logic               sounding;

    assign sounding = play_i && (delay_q != '0);

    always_comb begin
        delay_d    = delay_q;
        half_cnt_d = half_cnt_q;
        phase_d    = phase_q;
        tone_o     = '0;
        if (load_i) begin
            delay_d    = delay_i;
            half_cnt_d = '0;
            phase_d    = 1'b1;
        end else if (sounding) begin
            if (half_cnt_q == delay_q - DELAY_W'(1)) begin
                half_cnt_d = '0;
                phase_d    = ~phase_q;
            end else begin
                half_cnt_d = half_cnt_q + DELAY_W'(1);
            end
        end
        if (sounding) begin
            tone_o = phase_q ? AMP : -AMP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            delay_q    <= '0;
            half_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            delay_q    <= delay_d;
            half_cnt_q <= half_cnt_d;
            phase_q    <= phase_d;
        end
    end

endmodule

// File: rtl/audio_sfx_scheduler.sv
// Fixed-priority scheduler sharing one tone datapath; each note is LOAD, WAIT, then BEAT_TICKS of PLAY.
// sample_out advances only on audio_out_allowed cycles; write_audio_out is that flag one cycle late.
module audio_sfx_scheduler
    import audio_sfx_pkg::*;
#(
    parameter int                 NUM_REQ    = NUM_SFX,
    parameter int                 ADDR_W     = 10,
    parameter int                 DELAY_W    = 19,
    parameter int                 BEAT_TICKS = 2500000,
    parameter int                 AMPLITUDE  = 100000000,
    parameter logic [NUM_REQ-1:0] LOOP_MASK  = NUM_REQ'(1)
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [DELAY_W-1:0]          rom_q,
    input  logic                        audio_out_allowed,
    output logic                        write_audio_out,
    output logic signed [31:0]          sample_out,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  active_id,
    output logic                        done
);

    localparam int                ID_W      = $clog2(NUM_REQ);
    localparam int                BEAT_W    = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_TICKS - 1);

    sfx_state_e           state_q, state_d;
    logic [ID_W-1:0]      active_id_q, active_id_d;
    logic [ADDR_W-1:0]    note_idx_q, note_idx_d;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0]   req_q, pending_q, pending_d;
    logic signed [31:0]   sample_q, sample_d;
    logic                 write_q, done_q, done_d;

    logic [NUM_REQ-1:0]   req_rise, eligible;
    logic                 grant_vld, granted, tone_load, last_note;
    logic [ID_W-1:0]      grant_id;
    logic signed [31:0]   tone;

    // Lowest eligible index wins; pending covers one-shots, live req covers looping requesters.
    always_comb begin
        req_rise  = req & ~req_q;
        eligible  = pending_q | (req & LOOP_MASK);
        grant_vld = |eligible;
        grant_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) grant_id = ID_W'(i);
        end
    end

    assign last_note = (int'(note_idx_q) + 1) >= TRACK_LEN[active_id_q];

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        note_idx_d  = note_idx_q;
        rom_addr_d  = rom_addr_q;
        beat_cnt_d  = beat_cnt_q;
        done_d      = 1'b0;
        granted     = 1'b0;
        tone_load   = 1'b0;
        if (state_q == ST_IDLE || (grant_vld && grant_id < active_id_q)) begin
            if (grant_vld) begin
                granted     = 1'b1;
                active_id_d = grant_id;
                note_idx_d  = '0;
                state_d     = ST_LOAD;
            end
        end else if (LOOP_MASK[active_id_q] && !req[active_id_q]) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    rom_addr_d = ADDR_W'(TRACK_BASE[active_id_q] + int'(note_idx_q));
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    tone_load  = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = ST_PLAY;
                end
                ST_PLAY: begin
                    if (beat_cnt_q != BEAT_LAST) begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end else if (!last_note) begin
                        note_idx_d = note_idx_q + ADDR_W'(1);
                        state_d    = ST_LOAD;
                    end else if (LOOP_MASK[active_id_q]) begin
                        note_idx_d = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // A fresh edge in the grant cycle wins over the clear, so that request replays afterwards.
        pending_d = pending_q;
        if (granted) pending_d[grant_id] = 1'b0;
        pending_d = pending_d | (req_rise & ~LOOP_MASK);
        sample_d  = audio_out_allowed ? tone : sample_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            active_id_q <= '0;
            note_idx_q  <= '0;
            rom_addr_q  <= '0;
            beat_cnt_q  <= '0;
            req_q       <= '0;
            pending_q   <= '0;
            sample_q    <= '0;
            write_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_id_q <= active_id_d;
            note_idx_q  <= note_idx_d;
            rom_addr_q  <= rom_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            req_q       <= req;
            pending_q   <= pending_d;
            sample_q    <= sample_d;
            write_q     <= audio_out_allowed;
            done_q      <= done_d;
        end
    end

    sfx_tone_gen #(
        .DELAY_W   (DELAY_W),
        .AMPLITUDE (AMPLITUDE)
    ) u_tone (
        .clk_i   (CLOCK_50),
        .reset_i (reset),
        .load_i  (tone_load),
        .delay_i (rom_q),
        .play_i  (state_q == ST_PLAY),
        .tone_o  (tone)
    );

    assign rom_addr        = rom_addr_q;
    assign write_audio_out = write_q;
    assign sample_out      = sample_q;
    assign busy            = (state_q != ST_IDLE);
    assign active_id       = active_id_q;
    assign done            = done_q;

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Scoreboard bench for audio_sfx_scheduler with short beats and a combinational ROM returning addr+4.
module tb_audio_sfx_scheduler;

    localparam int BEAT = 8;
    localparam int NOTE_CYC = BEAT + 2;
    localparam logic signed [31:0] AMP = 32'sd100000000;
    localparam int T_BASE [4] = '{0, 16, 32, 48};
    localparam int T_LEN  [4] = '{3, 2, 2, 4};

    logic               CLOCK_50 = 1'b0;
    logic               reset;
    logic [3:0]         req;
    logic [9:0]         rom_addr;
    logic [18:0]        rom_q;
    logic               audio_out_allowed;
    logic               write_audio_out;
    logic signed [31:0] sample_out;
    logic               busy;
    logic [1:0]         active_id;
    logic               done;
    logic               rom_zero;

    int checks = 0;
    int errors = 0;
    logic [9:0]         addr_q [$];
    logic signed [31:0] smp_q  [$];

    always #5 CLOCK_50 = ~CLOCK_50;

    assign rom_q = rom_zero ? 19'd0 : 19'(rom_addr) + 19'd4;

    audio_sfx_scheduler #(
        .NUM_REQ    (4),
        .ADDR_W     (10),
        .DELAY_W    (19),
        .BEAT_TICKS (BEAT),
        .AMPLITUDE  (100000000),
        .LOOP_MASK  (4'b0001)
    ) dut (
        .CLOCK_50          (CLOCK_50),
        .reset             (reset),
        .req               (req),
        .rom_addr          (rom_addr),
        .rom_q             (rom_q),
        .audio_out_allowed (audio_out_allowed),
        .write_audio_out   (write_audio_out),
        .sample_out        (sample_out),
        .busy              (busy),
        .active_id         (active_id),
        .done              (done)
    );

    task automatic step();
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; audio_out_allowed = 1'b1; rom_zero = 1'b0;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
        checks++; if (sample_out !== 32'sd0) begin errors++; $display("FAIL reset_sample got %0d want 0", sample_out); end
        checks++; if (done !== 1'b0 || active_id !== 2'd0 || write_audio_out !== 1'b0) begin
            errors++; $display("FAIL reset_flags got done=%0b id=%0d wr=%0b want 0 0 0", done, active_id, write_audio_out);
        end
        reset = 1'b0;
        step();
        checks++; if (write_audio_out !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release got wr=%0b busy=%0b want 1 0", write_audio_out, busy);
        end
    endtask

    // Every rom_addr change is checked against the queue; a note holds its address LOAD..LOAD = BEAT+2 cycles.
    task automatic test_oneshot();
        logic [9:0] prev, want;
        int run, dones;
        bit seen_busy, finished, started;
        addr_q.delete();
        for (int k = 0; k < T_LEN[1]; k++) addr_q.push_back(10'(T_BASE[1] + k));
        prev = rom_addr; run = 0; dones = 0; seen_busy = 0; finished = 0; started = 0;
        req = 4'b0010;
        step();
        req = 4'b0000;
        for (int c = 0; c < 200 && !finished; c++) begin
            step();
            if (done === 1'b1) dones++;
            if (busy === 1'b1) seen_busy = 1;
            if (rom_addr !== prev) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++; $display("FAIL oneshot_addr got %0d want no further change", rom_addr);
                end else begin
                    want = addr_q.pop_front();
                    if (rom_addr !== want) begin errors++; $display("FAIL oneshot_addr got %0d want %0d", rom_addr, want); end
                end
                if (started) begin
                    checks++; if (run != NOTE_CYC) begin errors++; $display("FAIL oneshot_hold got %0d want %0d", run, NOTE_CYC); end
                end
                started = 1; run = 1; prev = rom_addr;
            end else begin
                run++;
            end
            if (seen_busy && busy === 1'b0) finished = 1;
        end
        checks++; if (!finished) begin errors++; $display("FAIL oneshot_timeout got busy=%0b want 0", busy); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL oneshot_done_at_end got %0b want 1", done); end
        checks++; if (run != NOTE_CYC) begin errors++; $display("FAIL oneshot_last_hold got %0d want %0d", run, NOTE_CYC); end
        checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL oneshot_missing got %0d left want 0", addr_q.size()); end
        step();
        checks++; if (dones != 1 || done !== 1'b0) begin errors++; $display("FAIL oneshot_done_count got %0d want 1", dones); end
    endtask

    task automatic test_loop();
        logic [9:0] prev, want;
        int run, dones;
        bit started, id_ok;
        addr_q.delete();
        for (int r = 0; r < 7; r++) addr_q.push_back(10'(T_BASE[0] + (r % T_LEN[0])));
        prev = rom_addr; run = 0; dones = 0; started = 0; id_ok = 1;
        req = 4'b0001;
        for (int c = 0; c < 200 && addr_q.size() > 0; c++) begin
            step();
            if (done === 1'b1) dones++;
            if (busy === 1'b1 && active_id !== 2'd0) id_ok = 0;
            if (rom_addr !== prev) begin
                want = addr_q.pop_front();
                checks++; if (rom_addr !== want) begin errors++; $display("FAIL loop_addr got %0d want %0d", rom_addr, want); end
                if (started) begin
                    checks++; if (run != NOTE_CYC) begin errors++; $display("FAIL loop_hold got %0d want %0d", run, NOTE_CYC); end
                end
                started = 1; run = 1; prev = rom_addr;
            end else begin
                run++;
            end
        end
        checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL loop_timeout got %0d left want 0", addr_q.size()); end
        req = 4'b0000;
        step();
        if (done === 1'b1) dones++;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_drop_idle got busy=%0b want 0", busy); end
        checks++; if (dones != 0) begin errors++; $display("FAIL loop_no_done got %0d want 0", dones); end
        checks++; if (!id_ok) begin errors++; $display("FAIL loop_active_id got other want 0"); end
    endtask

    task automatic test_preempt();
        bit found;
        int dones, busy_cnt;
        found = 0; dones = 0; busy_cnt = 0;
        req = 4'b0010;
        step();
        req = 4'b0000;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (rom_addr === 10'd16 && busy === 1'b1) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL preempt_start got addr=%0d want 16", rom_addr); end
        checks++; if (active_id !== 2'd1) begin errors++; $display("FAIL preempt_id_before got %0d want 1", active_id); end
        repeat (4) step();
        req = 4'b0001;
        step();
        checks++; if (active_id !== 2'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL preempt_id_after got id=%0d busy=%0b want 0 1", active_id, busy);
        end
        step();
        checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL preempt_addr got %0d want 0", rom_addr); end
        for (int c = 0; c < 40; c++) begin step(); if (done === 1'b1) dones++; end
        req = 4'b0000;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL preempt_drop got busy=%0b want 0", busy); end
        for (int c = 0; c < 20; c++) begin
            step();
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busy_cnt++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL preempt_no_done got %0d want 0", dones); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL preempt_no_resume got %0d busy cycles want 0", busy_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] prev, want;
        int dones;
        addr_q.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < T_LEN[1]; k++) addr_q.push_back(10'(T_BASE[1] + k));
        prev = rom_addr; dones = 0;
        for (int c = 0; c < 150 && dones < 2; c++) begin
            req = (c == 0 || c == 15) ? 4'b0010 : 4'b0000;
            step();
            if (done === 1'b1) dones++;
            if (rom_addr !== prev) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++; $display("FAIL b2b_addr got %0d want no further change", rom_addr);
                end else begin
                    want = addr_q.pop_front();
                    if (rom_addr !== want) begin errors++; $display("FAIL b2b_addr got %0d want %0d", rom_addr, want); end
                end
                prev = rom_addr;
            end
        end
        req = 4'b0000;
        checks++; if (dones != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", dones); end
        checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL b2b_missing got %0d left want 0", addr_q.size()); end
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%0b want 0", busy); end
    endtask

    // rom_q=4: four +AMP samples, four -AMP, then LOAD/WAIT silence; the sample register lags the tone by one.
    task automatic test_tone();
        logic signed [31:0] want;
        bit found;
        smp_q.delete();
        for (int k = 0; k < 4; k++) smp_q.push_back(AMP);
        for (int k = 0; k < 4; k++) smp_q.push_back(-AMP);
        smp_q.push_back(32'sd0);
        smp_q.push_back(32'sd0);
        rom_zero = 1'b0; req = 4'b0001; found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (sample_out !== 32'sd0) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL tone_start got %0d want nonzero", sample_out); end
        while (found && smp_q.size() > 0) begin
            want = smp_q.pop_front();
            checks++; if (sample_out !== want) begin errors++; $display("FAIL tone_sample got %0d want %0d", sample_out, want); end
            if (smp_q.size() > 0) step();
        end
        req = 4'b0000;
        repeat (2) step();
    endtask

    task automatic test_rest();
        int nonzero, dones;
        bit seen_busy, finished;
        nonzero = 0; dones = 0; seen_busy = 0; finished = 0;
        rom_zero = 1'b1;
        req = 4'b0100;
        step();
        req = 4'b0000;
        for (int c = 0; c < 100 && !finished; c++) begin
            step();
            if (sample_out !== 32'sd0) nonzero++;
            if (done === 1'b1) dones++;
            if (busy === 1'b1) seen_busy = 1;
            if (seen_busy && busy === 1'b0) finished = 1;
        end
        rom_zero = 1'b0;
        checks++; if (!finished) begin errors++; $display("FAIL rest_timeout got busy=%0b want 0", busy); end
        checks++; if (nonzero != 0) begin errors++; $display("FAIL rest_silent got %0d nonzero samples want 0", nonzero); end
        checks++; if (dones != 1) begin errors++; $display("FAIL rest_done got %0d want 1", dones); end
    endtask

    task automatic test_backpressure();
        logic signed [31:0] held;
        bit found;
        found = 0;
        req = 4'b0001;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (sample_out !== 32'sd0) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL bp_start got %0d want nonzero", sample_out); end
        held = sample_out;
        audio_out_allowed = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (write_audio_out !== 1'b0) begin errors++; $display("FAIL bp_write got %0b want 0", write_audio_out); end
            checks++; if (sample_out !== held) begin errors++; $display("FAIL bp_hold got %0d want %0d", sample_out, held); end
        end
        audio_out_allowed = 1'b1;
        step();
        checks++; if (write_audio_out !== 1'b1) begin errors++; $display("FAIL bp_resume got %0b want 1", write_audio_out); end
        req = 4'b0000;
        repeat (2) step();
    endtask

    task automatic test_reset_midplay();
        bit found;
        int dones, busy_cnt;
        found = 0; dones = 0; busy_cnt = 0;
        req = 4'b1000;
        step();
        req = 4'b0000;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (rom_addr === 10'd48 && busy === 1'b1) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_start got addr=%0d want 48", rom_addr); end
        repeat (3) step();
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || sample_out !== 32'sd0 || rom_addr !== 10'd0) begin
            errors++; $display("FAIL rstmid_clear got busy=%0b sample=%0d addr=%0d want 0 0 0", busy, sample_out, rom_addr);
        end
        checks++; if (done !== 1'b0 || active_id !== 2'd0) begin
            errors++; $display("FAIL rstmid_flags got done=%0b id=%0d want 0 0", done, active_id);
        end
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busy_cnt++;
        end
        checks++; if (dones != 0 || busy_cnt != 0) begin
            errors++; $display("FAIL rstmid_after got done=%0d busy=%0d want 0 0", dones, busy_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; audio_out_allowed = 1'b1; rom_zero = 1'b0;
        test_reset();
        test_oneshot();
        test_loop();
        test_preempt();
        test_back_to_back();
        test_tone();
        test_rest();
        test_backpressure();
        test_reset_midplay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
